// File: rtl/commit_stage_nport_if.sv
// rtl/commit_stage_nport_if.sv - shared types and scoreboard/regfile/CSR/LSU bundle for commit_stage_nport
package commit_stage_nport_pkg;

   typedef enum logic [2:0] {
      FU_NONE,
      FU_ALU,
      FU_LOAD,
      FU_STORE,
      FU_CSR,
      FU_CTRL
   } fu_t;

   typedef enum logic [3:0] {
      ADD,
      SUB,
      LD,
      SD,
      CSR_WRITE,
      CSR_READ,
      CSR_SET,
      CSR_CLEAR,
      FENCE,
      FENCE_I,
      SFENCE_VMA
   } fu_op;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0] pc;
      fu_t         fu;
      fu_op        op;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
      exception_t  ex;
   } scoreboard_entry_t;

endpackage

interface commit_stage_nport_if #(
   parameter int NR_COMMIT_PORTS = 4,
   parameter int CNT_WIDTH       = 64
) ();
   import commit_stage_nport_pkg::*;

   logic                             halt_i;
   logic                             flush_dcache_i;
   scoreboard_entry_t                commit_instr_i [NR_COMMIT_PORTS];
   logic [NR_COMMIT_PORTS-1:0]       commit_ack_o;
   logic [NR_COMMIT_PORTS-1:0][4:0]  waddr_o;
   logic [NR_COMMIT_PORTS-1:0][63:0] wdata_o;
   logic [NR_COMMIT_PORTS-1:0]       we_o;
   exception_t                       exception_o;
   logic [63:0]                      pc_o;
   fu_op                             csr_op_o;
   logic [63:0]                      csr_wdata_o;
   logic [63:0]                      csr_rdata_i;
   exception_t                       csr_exception_i;
   logic                             commit_csr_o;
   logic                             commit_lsu_o;
   logic                             commit_lsu_ready_i;
   logic                             no_st_pending_i;
   logic                             fence_i_o;
   logic                             fence_o;
   logic                             sfence_vma_o;
   logic [CNT_WIDTH-1:0]             instret_o;
`ifdef COMMIT_STALL_CNT_EN
   logic [CNT_WIDTH-1:0]             stall_cnt_o;
`endif

   // commit stage side
   modport slave (
      input  halt_i, flush_dcache_i, commit_instr_i, csr_rdata_i, csr_exception_i,
      input  commit_lsu_ready_i, no_st_pending_i,
      output commit_ack_o, waddr_o, wdata_o, we_o, exception_o, pc_o,
      output csr_op_o, csr_wdata_o, commit_csr_o, commit_lsu_o,
      output fence_i_o, fence_o, sfence_vma_o, instret_o
`ifdef COMMIT_STALL_CNT_EN
      , output stall_cnt_o
`endif
   );

   // scoreboard / CSR / LSU / controller side
   modport master (
      output halt_i, flush_dcache_i, commit_instr_i, csr_rdata_i, csr_exception_i,
      output commit_lsu_ready_i, no_st_pending_i,
      input  commit_ack_o, waddr_o, wdata_o, we_o, exception_o, pc_o,
      input  csr_op_o, csr_wdata_o, commit_csr_o, commit_lsu_o,
      input  fence_i_o, fence_o, sfence_vma_o, instret_o
`ifdef COMMIT_STALL_CNT_EN
      , input stall_cnt_o
`endif
   );

endinterface

// File: rtl/commit_stage_nport.sv
// rtl/commit_stage_nport.sv - N-wide in-order commit stage with fence drain FSM; optional stall counter via COMMIT_STALL_CNT_EN
module commit_stage_nport #(
   parameter int NR_COMMIT_PORTS = 4,
   parameter int CNT_WIDTH       = 64
) (
   input logic                  clk_i,
   input logic                  rst_i,
   commit_stage_nport_if.slave  bus
);
   import commit_stage_nport_pkg::*;

   typedef enum logic [0:0] {
      ST_RUN,
      ST_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      FK_FENCE,
      FK_FENCE_I,
      FK_SFENCE_VMA
   } fence_kind_t;

   state_t                           state_q, state_d;
   fence_kind_t                      kind_q, kind_d;
   logic [CNT_WIDTH-1:0]             instret_q, instret_d;

   exception_t                       exc;
   logic [NR_COMMIT_PORTS-1:0]       ack;
   logic [NR_COMMIT_PORTS-1:0]       we;
   logic [NR_COMMIT_PORTS-1:0][63:0] wdata;
   logic                             commit_lsu;
   logic                             commit_csr;
   fu_op                             csr_op;
   logic [63:0]                      csr_wdata;
   logic                             chain;
   logic                             store_used;
   logic                             pulse;
   fence_kind_t                      pulse_kind;
   logic                             fence0;
   fence_kind_t                      fence_kind0;
   logic [NR_COMMIT_PORTS-1:0]       retired;
   logic [CNT_WIDTH-1:0]             retire_inc;

   function automatic logic is_fence_op(input fu_op op);
      return (op == FENCE) || (op == FENCE_I) || (op == SFENCE_VMA);
   endfunction

   // Port-0 exception select: interrupt beats the entry's own exception, which beats a CSR trap
   always_comb begin
      exc = '0;
      if (bus.commit_instr_i[0].valid && !rst_i) begin
         if (bus.csr_exception_i.valid && !bus.csr_exception_i.cause[63]) begin
            exc       = bus.csr_exception_i;
            exc.tval  = bus.commit_instr_i[0].ex.tval;
         end
         if (bus.commit_instr_i[0].ex.valid) begin
            exc = bus.commit_instr_i[0].ex;
         end
         if (bus.csr_exception_i.valid && bus.csr_exception_i.cause[63]) begin
            exc       = bus.csr_exception_i;
            exc.tval  = bus.commit_instr_i[0].ex.tval;
         end
      end
      if (bus.halt_i) begin
         exc.valid = 1'b0;
      end
   end

   // Classify port 0 as a fence; a dcache flush piggybacks as FENCE_I unless a store sits there
   always_comb begin
      fence0      = 1'b0;
      fence_kind0 = FK_FENCE_I;
      if (is_fence_op(bus.commit_instr_i[0].op) ||
          (bus.flush_dcache_i && bus.commit_instr_i[0].fu != FU_STORE)) begin
         fence0 = 1'b1;
      end
      if (bus.commit_instr_i[0].op == FENCE) begin
         fence_kind0 = FK_FENCE;
      end else if (bus.commit_instr_i[0].op == SFENCE_VMA) begin
         fence_kind0 = FK_SFENCE_VMA;
      end
   end

   // Commit chain and fence FSM next-state; a fence or CSR ends the chain so younger entries
   // never retire alongside a pipeline flush
   always_comb begin
      ack        = '0;
      we         = '0;
      commit_lsu = 1'b0;
      commit_csr = 1'b0;
      csr_op     = ADD;
      csr_wdata  = '0;
      chain      = 1'b1;
      store_used = 1'b0;
      pulse      = 1'b0;
      pulse_kind = kind_q;
      state_d    = state_q;
      kind_d     = kind_q;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         wdata[k] = bus.commit_instr_i[k].result;
      end

      if (!rst_i) begin
         if (state_q == ST_DRAIN) begin
            if (exc.valid) begin
               ack[0]  = 1'b1;
               state_d = ST_RUN;
            end else if (bus.no_st_pending_i && !bus.halt_i) begin
               ack[0]     = 1'b1;
               we[0]      = 1'b1;
               pulse      = 1'b1;
               pulse_kind = kind_q;
               state_d    = ST_RUN;
            end
         end else begin
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
               if (chain) begin
                  if (!bus.commit_instr_i[k].valid || bus.halt_i) begin
                     chain = 1'b0;
                  end else if (k == 0 && exc.valid) begin
                     ack[0] = 1'b1;
                     chain  = 1'b0;
                  end else if (k != 0 && (bus.commit_instr_i[k].ex.valid || bus.flush_dcache_i)) begin
                     chain = 1'b0;
                  end else if (k == 0 && fence0) begin
                     chain = 1'b0;
                     if (bus.no_st_pending_i) begin
                        ack[0]     = 1'b1;
                        we[0]      = 1'b1;
                        pulse      = 1'b1;
                        pulse_kind = fence_kind0;
                     end else begin
                        state_d = ST_DRAIN;
                        kind_d  = fence_kind0;
                     end
                  end else if (is_fence_op(bus.commit_instr_i[k].op)) begin
                     chain = 1'b0;
                  end else if (bus.commit_instr_i[k].fu == FU_CSR) begin
                     chain = 1'b0;
                     if (k == 0) begin
                        ack[0]     = 1'b1;
                        we[0]      = 1'b1;
                        commit_csr = 1'b1;
                        csr_op     = bus.commit_instr_i[0].op;
                        csr_wdata  = bus.commit_instr_i[0].result;
                        wdata[0]   = bus.csr_rdata_i;
                     end
                  end else if (bus.commit_instr_i[k].fu == FU_STORE) begin
                     if (store_used || !bus.commit_lsu_ready_i) begin
                        chain = 1'b0;
                     end else begin
                        ack[k]     = 1'b1;
                        we[k]      = 1'b1;
                        commit_lsu = 1'b1;
                        store_used = 1'b1;
                     end
                  end else begin
                     ack[k] = 1'b1;
                     we[k]  = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Retire count excludes a port-0 entry that is acknowledged only to raise its exception
   always_comb begin
      retired    = ack;
      retired[0] = ack[0] & ~exc.valid;
      retire_inc = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         retire_inc = retire_inc + {{(CNT_WIDTH-1){1'b0}}, retired[k]};
      end
      instret_d = instret_q + retire_inc;
   end

   // FSM, latched fence kind and retire counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         kind_q    <= FK_FENCE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         instret_q <= instret_d;
      end
   end

`ifdef COMMIT_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // Count cycles where the oldest entry is waiting but not retiring
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.commit_instr_i[0].valid && !ack[0]) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Stall counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`endif

   assign bus.commit_ack_o = ack;
   assign bus.we_o         = we;
   assign bus.wdata_o      = wdata;
   assign bus.exception_o  = exc;
   assign bus.pc_o         = bus.commit_instr_i[0].pc;
   assign bus.csr_op_o     = csr_op;
   assign bus.csr_wdata_o  = csr_wdata;
   assign bus.commit_csr_o = commit_csr;
   assign bus.commit_lsu_o = commit_lsu;
   assign bus.fence_o      = pulse && (pulse_kind == FK_FENCE);
   assign bus.fence_i_o    = pulse && (pulse_kind == FK_FENCE_I);
   assign bus.sfence_vma_o = pulse && (pulse_kind == FK_SFENCE_VMA);
   assign bus.instret_o    = instret_q;

   generate
      for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_waddr
         assign bus.waddr_o[g] = bus.commit_instr_i[g].rd;
      end
   endgenerate

endmodule

// File: tb/tb_commit_stage_nport.sv
// tb/tb_commit_stage_nport.sv - directed table-driven bench for commit_stage_nport
module tb_commit_stage_nport;
   import commit_stage_nport_pkg::*;

   localparam int NR = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   commit_stage_nport_if #(.NR_COMMIT_PORTS(NR), .CNT_WIDTH(CW)) bus ();

   commit_stage_nport #(.NR_COMMIT_PORTS(NR), .CNT_WIDTH(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // kind per port, 2 bits each (port 0 in [1:0]): 0 ALU, 1 STORE, 2 CSR, 3 FENCE
   typedef struct {
      string      name;
      logic [7:0] kind;
      logic [3:0] valid;
      logic [3:0] exv;
      logic       lsu_rdy;
      logic       nsp;
      logic       flush;
      logic       halt;
      logic [3:0] exp_ack;
      logic [3:0] exp_we;
      logic       exp_lsu;
      logic       exp_csr;
      logic       exp_exc;
      logic [2:0] exp_pulse;   // {fence_i, fence, sfence_vma}
   } vec_t;

   vec_t vecs [13];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_entries(input logic [7:0] kind, input logic [3:0] valid, input logic [3:0] exv);
      scoreboard_entry_t e;
      for (int k = 0; k < NR; k++) begin
         e          = '0;
         e.pc       = 64'h1000 + 64'(4 * k);
         e.rd       = 5'(k + 1);
         e.result   = 64'hA000 + 64'(k);
         e.valid    = valid[k];
         e.ex.cause = 64'd2;
         e.ex.tval  = 64'hBAD0 + 64'(k);
         e.ex.valid = exv[k];
         case (kind[2*k +: 2])
            2'd0:    begin e.fu = FU_ALU;   e.op = ADD;       end
            2'd1:    begin e.fu = FU_STORE; e.op = SD;        end
            2'd2:    begin e.fu = FU_CSR;   e.op = CSR_WRITE; end
            default: begin e.fu = FU_NONE;  e.op = FENCE;     end
         endcase
         bus.commit_instr_i[k] = e;
      end
   endtask

   task automatic idle_inputs();
      bus.halt_i             = 1'b0;
      bus.flush_dcache_i     = 1'b0;
      bus.commit_lsu_ready_i = 1'b1;
      bus.no_st_pending_i    = 1'b1;
      bus.csr_rdata_i        = 64'hC5C5;
      bus.csr_exception_i    = '0;
      set_entries(8'h00, 4'b0000, 4'b0000);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [2:0] pulses();
      return {bus.fence_i_o, bus.fence_o, bus.sfence_vma_o};
   endfunction

   initial begin
      logic [CW-1:0] saved;

      vecs[0]  = '{"all_alu",     8'b00_00_00_00, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b1111, 4'b1111, 0, 0, 0, 3'b000};
      vecs[1]  = '{"two_stores",  8'b00_01_01_00, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b0011, 4'b0011, 1, 0, 0, 3'b000};
      vecs[2]  = '{"st_not_rdy",  8'b00_00_00_01, 4'b1111, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 3'b000};
      vecs[3]  = '{"csr_p0",      8'b00_00_00_10, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b0001, 4'b0001, 0, 1, 0, 3'b000};
      vecs[4]  = '{"csr_p2",      8'b00_10_00_00, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b0011, 4'b0011, 0, 0, 0, 3'b000};
      vecs[5]  = '{"halt",        8'b00_00_00_00, 4'b1111, 4'b0000, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 3'b000};
      vecs[6]  = '{"p1_invalid",  8'b00_00_00_00, 4'b1101, 4'b0000, 1, 1, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 3'b000};
      vecs[7]  = '{"ex_p0",       8'b00_00_00_00, 4'b1111, 4'b0001, 1, 1, 0, 0, 4'b0001, 4'b0000, 0, 0, 1, 3'b000};
      vecs[8]  = '{"ex_p2",       8'b00_00_00_00, 4'b1111, 4'b0100, 1, 1, 0, 0, 4'b0011, 4'b0011, 0, 0, 0, 3'b000};
      vecs[9]  = '{"flush_store", 8'b00_00_00_01, 4'b1111, 4'b0000, 1, 1, 1, 0, 4'b0001, 4'b0001, 1, 0, 0, 3'b000};
      vecs[10] = '{"fence_ready", 8'b00_00_00_11, 4'b0001, 4'b0000, 1, 1, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 3'b010};
      vecs[11] = '{"halt_ex",     8'b00_00_00_00, 4'b1111, 4'b0001, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 3'b000};
      vecs[12] = '{"flush_alu",   8'b00_00_00_00, 4'b1111, 4'b0000, 1, 1, 1, 0, 4'b0001, 4'b0001, 0, 0, 0, 3'b100};

      // Reset: outputs held at defaults even with work presented
      rst = 1'b1;
      idle_inputs();
      set_entries(8'h00, 4'b1111, 4'b0001);
      tick();
      tick();
      #2;
      chk("rst.instret", 64'(bus.instret_o), 64'd0);
      chk("rst.ack", 64'(bus.commit_ack_o), 64'd0);
      chk("rst.we", 64'(bus.we_o), 64'd0);
      chk("rst.csr_op", 64'(bus.csr_op_o), 64'(ADD));
      chk("rst.exc_valid", 64'(bus.exception_o.valid), 64'd0);
      rst = 1'b0;
      tick();

      // Table of single-cycle commit patterns, all in RUN
      for (int i = 0; i < 13; i++) begin
         idle_inputs();
         set_entries(vecs[i].kind, vecs[i].valid, vecs[i].exv);
         bus.commit_lsu_ready_i = vecs[i].lsu_rdy;
         bus.no_st_pending_i    = vecs[i].nsp;
         bus.flush_dcache_i     = vecs[i].flush;
         bus.halt_i             = vecs[i].halt;
         #2;
         chk($sformatf("%s.ack", vecs[i].name), 64'(bus.commit_ack_o), 64'(vecs[i].exp_ack));
         chk($sformatf("%s.we", vecs[i].name), 64'(bus.we_o), 64'(vecs[i].exp_we));
         chk($sformatf("%s.lsu", vecs[i].name), 64'(bus.commit_lsu_o), 64'(vecs[i].exp_lsu));
         chk($sformatf("%s.csr", vecs[i].name), 64'(bus.commit_csr_o), 64'(vecs[i].exp_csr));
         chk($sformatf("%s.exc", vecs[i].name), 64'(bus.exception_o.valid), 64'(vecs[i].exp_exc));
         chk($sformatf("%s.pulse", vecs[i].name), 64'(pulses()), 64'(vecs[i].exp_pulse));
         if (vecs[i].exp_csr) begin
            chk($sformatf("%s.wdata0", vecs[i].name), bus.wdata_o[0], 64'hC5C5);
            chk($sformatf("%s.csr_wdata", vecs[i].name), bus.csr_wdata_o, 64'hA000);
         end
         tick();
      end

      // Retire counter: 0 -> 4, then up to 14, then 3 more wraps to 1
      do_reset();
      set_entries(8'h00, 4'b1111, 4'b0000);
      tick();
      chk("instret.first", 64'(bus.instret_o), 64'd4);
      tick();
      tick();
      set_entries(8'h00, 4'b0011, 4'b0000);
      tick();
      chk("instret.pre_wrap", 64'(bus.instret_o), 64'd14);
      set_entries(8'h00, 4'b0111, 4'b0000);
      tick();
      chk("instret.wrap", 64'(bus.instret_o), 64'd1);

      // Second store follows next cycle from port 0
      set_entries(8'b00_01_01_00, 4'b1111, 4'b0000);
      #2;
      chk("st_seq.ack1", 64'(bus.commit_ack_o), 64'b0011);
      tick();
      set_entries(8'b00_00_00_01, 4'b0011, 4'b0000);
      #2;
      chk("st_seq.ack2", 64'(bus.commit_ack_o), 64'b0011);
      chk("st_seq.lsu2", 64'(bus.commit_lsu_o), 64'd1);
      tick();

      // FENCE waits three cycles for store drain, then one-cycle pulse
      do_reset();
      set_entries(8'b00_00_00_11, 4'b0001, 4'b0000);
      bus.no_st_pending_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("drain.ack_c%0d", c), 64'(bus.commit_ack_o), 64'd0);
         chk($sformatf("drain.pulse_c%0d", c), 64'(pulses()), 64'd0);
         tick();
      end
      bus.no_st_pending_i = 1'b1;
      #2;
      chk("drain.ack_done", 64'(bus.commit_ack_o), 64'b0001);
      chk("drain.pulse_done", 64'(pulses()), 64'b010);
      saved = bus.instret_o;
      tick();
      chk("drain.instret", 64'(bus.instret_o), 64'(CW'(saved + 1'b1)));
      set_entries(8'h00, 4'b0000, 4'b0000);
      #2;
      chk("drain.pulse_after", 64'(pulses()), 64'd0);
      chk("drain.ack_after", 64'(bus.commit_ack_o), 64'd0);
      tick();

      // Interrupt beats port-0 exception; tval from the entry; no retire
      set_entries(8'h00, 4'b1111, 4'b0001);
      bus.csr_exception_i = '{cause: {1'b1, 63'd7}, tval: 64'h1234, valid: 1'b1};
      saved = bus.instret_o;
      #2;
      chk("irq.cause", bus.exception_o.cause, {1'b1, 63'd7});
      chk("irq.tval", bus.exception_o.tval, 64'hBAD0);
      chk("irq.valid", 64'(bus.exception_o.valid), 64'd1);
      chk("irq.ack", 64'(bus.commit_ack_o), 64'b0001);
      chk("irq.we", 64'(bus.we_o), 64'd0);
      tick();
      chk("irq.instret", 64'(bus.instret_o), 64'(saved));
      bus.csr_exception_i = '0;

      // Exception arriving during DRAIN: ack, no pulse, back to RUN
      set_entries(8'b00_00_00_11, 4'b0001, 4'b0000);
      bus.no_st_pending_i = 1'b0;
      tick();
      set_entries(8'b00_00_00_11, 4'b0001, 4'b0001);
      #2;
      chk("drain_ex.ack", 64'(bus.commit_ack_o), 64'b0001);
      chk("drain_ex.we", 64'(bus.we_o), 64'd0);
      chk("drain_ex.pulse", 64'(pulses()), 64'd0);
      chk("drain_ex.exc", 64'(bus.exception_o.valid), 64'd1);
      tick();
      set_entries(8'h00, 4'b0001, 4'b0000);
      #2;
      chk("drain_ex.run", 64'(bus.commit_ack_o), 64'b0001);
      tick();

      // Reset mid-DRAIN abandons the fence
      set_entries(8'b00_00_00_11, 4'b0001, 4'b0000);
      bus.no_st_pending_i = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      bus.no_st_pending_i = 1'b1;
      #2;
      chk("rst_drain.pulse", 64'(pulses()), 64'd0);
      chk("rst_drain.ack", 64'(bus.commit_ack_o), 64'd0);
      tick();
      rst = 1'b0;
      set_entries(8'h00, 4'b0001, 4'b0000);
      bus.no_st_pending_i = 1'b0;
      #2;
      chk("rst_drain.run_ack", 64'(bus.commit_ack_o), 64'b0001);
      chk("rst_drain.pulse_after", 64'(pulses()), 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/commit_stage_nport.md
Name: commit_stage_nport

Overview:
N-wide commit stage that retires up to NR_COMMIT_PORTS in-order scoreboard entries per cycle into the register file, LSU, CSR file and controller.
- Adds a sequential fence-drain FSM, so FENCE / FENCE_I / SFENCE_VMA / dcache-flush wait for store drain in a dedicated state.
- Any port may commit the single store allowed per cycle.
- Keeps a wrapping retired-instruction counter.
- Sits between the scoreboard and the register file / CSR / controller.

Parameters:
NR_COMMIT_PORTS, 4, number of commit ports (2..8).
CNT_WIDTH, 64, width of the retire counter and the optional stall counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
halt_i  in  1  halt request; blocks all commits and exceptions
flush_dcache_i  in  1  dcache flush request; handled as FENCE_I
commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  oldest entry at index 0
commit_ack_o  out  NR_COMMIT_PORTS  per-port acknowledge
waddr_o  out  NR_COMMIT_PORTS x 5  rd[4:0] of each port
wdata_o  out  NR_COMMIT_PORTS x 64  result; csr_rdata_i on a port-0 CSR
we_o  out  NR_COMMIT_PORTS  register-file write enable
exception_o  out  exception_t  exception to controller
pc_o  out  64  commit_instr_i[0].pc
csr_op_o  out  fu_op  CSR op; ADD when idle
csr_wdata_o  out  64  CSR write data
csr_rdata_i  in  64  CSR read data
csr_exception_i  in  exception_t  CSR exception or interrupt
commit_csr_o  out  1  commit pending CSR
commit_lsu_o  out  1  commit one pending store
commit_lsu_ready_i  in  1  LSU commit buffer ready
no_st_pending_i  in  1  store buffer empty
fence_i_o, fence_o, sfence_vma_o  out  1 each  one-cycle flush pulses
instret_o  out  CNT_WIDTH  retired-instruction count

Behaviour:
Reset (rst_i=1 at a clock edge):
- FSM -> RUN; instret_o -> 0.
- Combinational outputs take their defaults: acks/we/commit_*/fence* = 0, csr_op_o = ADD, csr_wdata_o = 0, exception_o.valid = 0.
- Reset mid-DRAIN abandons the fence; no pulse is issued.

Exception logic (combinational, port 0 only):
- Requires commit_instr_i[0].valid.
- Priority: CSR interrupt (cause[63]=1) > instr[0].ex > CSR synchronous exception.
- tval for CSR-sourced exceptions = instr[0].ex.tval.
- halt_i forces exception_o.valid = 0.

Per-port commit chain in RUN, port k:
- Port k acks only if all of: ports 0..k-1 acked, valid, !halt_i, no exception, and the fu/op checks below pass. The first non-acking port stops the chain.
- Port 0 with an exception: ack[0]=1, we[0]=0, chain stops.
- Port k>0 with ex.valid: not acked.
- STORE: at most one per cycle. It needs commit_lsu_ready_i, and drives commit_lsu_o=1. A second store in the same cycle stops the chain.
- CSR: port 0 only. Drives commit_csr_o, csr_op_o = op, csr_wdata_o = result, wdata_o[0] = csr_rdata_i; chain stops after port 0. A CSR at k>0 stops the chain.
- we[k] = ack[k] and no exception.
- flush_dcache_i=1 blocks ports >=1.

Fence handling:
- Port 0 op in {FENCE, FENCE_I, SFENCE_VMA}, or flush_dcache_i with a non-STORE at port 0, and no exception:
  - If no_st_pending_i=1: acked in the same cycle with the matching pulse.
  - Otherwise: no ack; latch the kind; go to DRAIN.
- DRAIN: all acks 0. When no_st_pending_i=1 and !halt_i: ack[0]=1, pulse the latched output for 1 cycle, then RUN next cycle.
- An exception or interrupt appearing on port 0 while in DRAIN takes priority: ack[0]=1, no pulse, -> RUN.

Retire counter:
- instret_o += popcount(ack & ~exception-on-port0).
- Updates each cycle; wraps modulo 2^CNT_WIDTH.

Optional Feature:
COMMIT_STALL_CNT_EN defined:
- Extra output stall_cnt_o [CNT_WIDTH], reset 0.
- Increments each cycle where commit_instr_i[0].valid=1 and commit_ack_o[0]=0; wraps.
Undefined:
- Port and counter absent.
- No other behaviour changes.

Test Plan:
- 4 valid ALU entries, no exceptions -> ack=4'b1111, we=4'b1111; instret_o 0->4 next cycle.
- Ports ALU, STORE, STORE, ALU with lsu_ready=1 -> ack=4'b0011, commit_lsu_o=1; next cycle with the second store at port 0 -> it commits.
- FENCE at port 0, no_st_pending_i=0 for 3 cycles then 1 -> acks 0 for 3 cycles in DRAIN; 4th cycle ack[0]=1, fence_o=1 for exactly 1 cycle.
- Port 0 ex.valid (cause 2) with csr_exception_i interrupt (cause[63]=1) -> exception_o = interrupt, tval = instr[0].ex.tval, ack[0]=1, we[0]=0, instret_o unchanged.
- CSR at port 0, ALU at 1..3 -> ack=4'b0001, commit_csr_o=1, wdata_o[0]=csr_rdata_i.
- instret_o preset to 2^CNT_WIDTH-2 via commits, 3 retire -> wraps to 1; rst_i mid-DRAIN -> state RUN, no fence pulse.
